serial_magnitude_comparator: RTL and testbench

//   Bit-serial magnitude comparator: compares two WIDTH-bit operands MSB-first, one bit per clock.

---
 rtl/serial_magnitude_comparator.sv | 160 ++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: walks two latched operands MSB-first, one bit per clock,
// through an eq/gt/lt cascade, with a start/busy/done handshake and optional early exit.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_COMPARE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sm_q, sm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ceq_q, ceq_d;
    logic               cgt_q, cgt_d;
    logic               clt_q, clt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic ai_c, bi_c, inv_c, bit_gt_c, bit_lt_c;
    logic ceq_n_c, cgt_n_c, clt_n_c, finish_c;

    // One cascade step on bit idx; the sign bit compares with inverted sense in signed mode.
    always_comb begin
        ai_c     = a_q[idx_q];
        bi_c     = b_q[idx_q];
        inv_c    = sm_q && (idx_q == IDX_MSB);
        bit_gt_c = inv_c ? (!ai_c && bi_c) : (ai_c && !bi_c);
        bit_lt_c = inv_c ? (ai_c && !bi_c) : (!ai_c && bi_c);
        ceq_n_c  = ceq_q;
        cgt_n_c  = cgt_q;
        clt_n_c  = clt_q;
        if (ceq_q) begin
            if (bit_gt_c) begin
                ceq_n_c = 1'b0;
                cgt_n_c = 1'b1;
                clt_n_c = 1'b0;
            end else if (bit_lt_c) begin
                ceq_n_c = 1'b0;
                cgt_n_c = 1'b0;
                clt_n_c = 1'b1;
            end
        end
        finish_c = (idx_q == '0) || ((EARLY_EXIT != 0) && !ceq_n_c);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= '0;
            ceq_q   <= 1'b0;
            cgt_q   <= 1'b0;
            clt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            ceq_q   <= ceq_d;
            cgt_q   <= cgt_d;
            clt_q   <= clt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        ceq_d   = ceq_q;
        cgt_d   = cgt_q;
        clt_d   = clt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    idx_d   = IDX_MSB;
                    ceq_d   = 1'b1;
                    cgt_d   = 1'b0;
                    clt_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                ceq_d = ceq_n_c;
                cgt_d = cgt_n_c;
                clt_d = clt_n_c;
                if (finish_c) begin
                    eq_d    = ceq_n_c;
                    gt_d    = cgt_n_c;
                    lt_d    = clt_n_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: one early-exit and one full-scan instance,
// latency counted in clock edges from the start edge, results given as {eq,gt,lt}.
module tb_serial_magnitude_comparator;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_ee = 1'b0;
    logic         start_ne = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sm = 1'b0;

    logic busy_ee, done_ee, eq_ee, gt_ee, lt_ee;
    logic busy_ne, done_ne, eq_ne, gt_ne, lt_ne;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;
    localparam logic [2:0] R_NONE = 3'b000;

    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start(start_ee), .a(a), .b(b), .signed_mode(sm),
        .busy(busy_ee), .done(done_ee), .eq(eq_ee), .gt(gt_ee), .lt(lt_ee)
    );

    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(0)) u_ne (
        .clk(clk), .rst_n(rst_n), .start(start_ne), .a(a), .b(b), .signed_mode(sm),
        .busy(busy_ne), .done(done_ne), .eq(eq_ne), .gt(gt_ne), .lt(lt_ne)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] res(input bit sel);
        return sel ? {eq_ne, gt_ne, lt_ne} : {eq_ee, gt_ee, lt_ee};
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done_ne : done_ee;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_ne : busy_ee;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands and a one-cycle start; returns at the negedge after edge 0.
    task automatic launch(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic smv);
        @(negedge clk);
        a = av;
        b = bv;
        sm = smv;
        if (sel) start_ne = 1'b1;
        else     start_ee = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_ee = 1'b0;
        start_ne = 1'b0;
    endtask

    // Counts further edges until done is seen (bounded); n0 edges already elapsed.
    task automatic wait_done(input bit sel, input int n0, output int n);
        n = n0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_of(sel)) break;
        end
    endtask

    task automatic run(input string tag, input bit sel, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic smv, input int exp_n,
                       input logic [2:0] exp_r);
        int n;
        launch(sel, av, bv, smv);
        wait_done(sel, 0, n);
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        chk({tag, "_result"}, 32'(res(sel)), 32'(exp_r));
        chk({tag, "_busy_at_done"}, 32'(busy_of(sel)), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_of(sel)), 32'd0);
        chk({tag, "_hold"}, 32'(res(sel)), 32'(exp_r));
    endtask

    initial begin
        int n;
        int seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy_ee", 32'(busy_ee), 32'd0);
        chk("rst_done_ee", 32'(done_ee), 32'd0);
        chk("rst_res_ee", 32'(res(1'b0)), 32'(R_NONE));
        chk("rst_res_ne", 32'(res(1'b1)), 32'(R_NONE));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy_ne", 32'(busy_ne), 32'd0);

        // Main function
        run("eq_a5", 1'b0, 8'hA5, 8'hA5, 1'b0, 8, R_EQ);
        run("msb_uns", 1'b0, 8'h80, 8'h7F, 1'b0, 1, R_GT);
        run("msb_sgn", 1'b0, 8'h80, 8'h7F, 1'b1, 1, R_LT);
        run("lsb_ee", 1'b0, 8'h03, 8'h02, 1'b0, 8, R_GT);
        run("lsb_ne", 1'b1, 8'h03, 8'h02, 1'b0, 8, R_GT);
        run("msb_ne", 1'b1, 8'h80, 8'h00, 1'b0, 8, R_GT);
        run("neg1_vs_1", 1'b0, 8'hFF, 8'h01, 1'b1, 1, R_LT);
        run("neg1_vs_1_ne", 1'b1, 8'hFF, 8'h01, 1'b1, 8, R_LT);
        run("fe_vs_ff", 1'b0, 8'hFE, 8'hFF, 1'b1, 8, R_LT);
        run("bit5", 1'b0, 8'h10, 8'h20, 1'b0, 3, R_LT);
        run("fe_vs_ff_uns_ne", 1'b1, 8'hFE, 8'hFF, 1'b0, 8, R_LT);

        // start at edge 2 ignored; operands change while busy
        launch(1'b0, 8'h03, 8'h02, 1'b0);
        a = 8'h00;
        b = 8'hFF;
        sm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_ee = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_ee = 1'b0;
        chk("hs_busy_mid", 32'(busy_ee), 32'd1);
        wait_done(1'b0, 2, n);
        chk("hs_ignore_latency", 32'(n), 32'd8);
        chk("hs_ignore_result", 32'(res(1'b0)), 32'(R_GT));
        @(negedge clk);
        chk("hs_no_extra_compare", 32'(busy_ee), 32'd0);

        // start held through done: second compare accepted on the done-cycle edge
        @(negedge clk);
        a = 8'h80;
        b = 8'h7F;
        sm = 1'b0;
        start_ee = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_first_done", 32'(done_ee), 32'd1);
        chk("b2b_first_result", 32'(res(1'b0)), 32'(R_GT));
        @(posedge clk);
        @(negedge clk);
        start_ee = 1'b0;
        chk("b2b_second_busy", 32'(busy_ee), 32'd1);
        chk("b2b_second_no_done", 32'(done_ee), 32'd0);
        wait_done(1'b0, 0, n);
        chk("b2b_second_latency", 32'(n), 32'd3);
        chk("b2b_second_result", 32'(res(1'b0)), 32'(R_LT));

        // Reset mid-compare at edge 3
        launch(1'b0, 8'h01, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_ee), 32'd0);
        chk("midrst_done", 32'(done_ee), 32'd0);
        chk("midrst_res", 32'(res(1'b0)), 32'(R_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_ee || busy_ee) seen = 1;
        end
        chk("midrst_no_late_done", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
